multi_edge_detector: RTL and testbench
======================================

Name: multi_edge_detector

Overview:
- Parametrised, multi-channel successor to the single-bit button edge detector.
- Per channel: synchronises an asynchronous level input and debounces it with a stability counter.
- Emits registered one-cycle rise/fall/edge pulses, selected by a mode input.
- Keeps a sticky pending flag per channel so a slow consumer (polling logic, interrupt controller) cannot miss an event.

Parameters:
- CH, 4: number of independent input channels (≥1).
- SYNC_STAGES, 2: flip-flops in each input synchroniser (≥2).
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronised level must differ from the stable level before it is accepted (≥1).
- CNT_W, 8: width of each per-channel edge counter (used only with EDGE_CNT_EN).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- level  in  CH  raw asynchronous level per channel.
- mode  in  2  edge qualification: 00 none, 01 rise only, 10 fall only, 11 both; global, sampled every cycle.
- clear  in  CH  per-channel clear of pending (and of edge_count when enabled).
- stable  out  CH  debounced level per channel.
- rise  out  CH  one-cycle pulse on each 0->1 transition of stable.
- fall  out  CH  one-cycle pulse on each 1->0 transition of stable.
- edges  out  CH  one-cycle pulse: (rise & mode[0]) | (fall & mode[1]).
- pending  out  CH  sticky flag, set by edges, cleared by clear.
- any_pending  out  1  OR-reduction of pending, registered.

Behaviour:
- Reset, asynchronous, while reset=1:
  - Synchroniser chains, stable, debounce counters, rise, fall, edges, pending, any_pending (and edge_count) all 0.
- Synchroniser:
  - level[i] passes through SYNC_STAGES flops, giving s[i].
  - No other logic touches level[i] directly.
- Debounce, per channel, counter width clog2(DEBOUNCE_CYCLES+1):
  - If s[i]==stable[i], the counter is set to 0.
  - Otherwise it increments.
  - When the counter is already DEBOUNCE_CYCLES-1 and s[i]!=stable[i], stable[i] takes s[i] on that edge and the counter returns to 0.
  - Any bounce back to stable[i] before then restarts the count; no change is accepted.
- Latency: a clean level change first sampled at edge 0 appears on stable, rise/fall and edges at edge SYNC_STAGES+DEBOUNCE_CYCLES-1 (defaults: 6 edges).
- Pulses:
  - rise/fall/edges are registered and assert in exactly the same cycle stable changes.
  - Each lasts exactly one cycle.
  - The minimum spacing between two pulses on one channel is DEBOUNCE_CYCLES cycles.
- Mode:
  - edges uses the mode value present on the edge where stable changes.
  - A mode change never creates or removes a pulse retroactively.
  - rise/fall are independent of mode.
- Pending:
  - Set on the cycle after edges[i]=1.
  - Cleared on the cycle after clear[i]=1.
  - A simultaneous edges[i] and clear[i] leaves pending[i]=1 (set wins).
  - clear on a channel with no pending is harmless.
- any_pending: registered OR of the next-state pending vector, so it is cycle-aligned with pending.
- Startup: stable resets to 0, so a level held at 1 through reset release produces one rise after the standard latency.
- Mid-operation reset: all in-progress counts are discarded; there are no pulses during reset and none generated by reset assertion or deassertion themselves.
- Channels are fully independent; simultaneous events on any subset are all reported in the same cycle.

Optional Feature:
- Macro: MULTI_EDGE_DETECTOR_EDGE_CNT_EN.
- When defined:
  - Adds output edge_count, CH*CNT_W bits; channel i occupies bits [i*CNT_W +: CNT_W].
  - Each counter increments on every edges[i] pulse and saturates at all-ones (no wrap).
  - It is cleared to 0 by clear[i]; a simultaneous edge and clear gives a count of 1.
  - Reset value is 0.
- When undefined: the port and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset released with level=4'b0000 and mode=2'b11, then level[0] driven 0->1 at edge 0 and held -> stable[0]=1, rise[0]=1 and edges[0]=1 at edge 5 for one cycle only; pending[0]=1 and any_pending=1 from edge 6.
2. level[1] toggled high for 3 cycles then low, repeated 5 times (bounce shorter than DEBOUNCE_CYCLES after sync) -> stable[1] stays 0; no rise/fall/edges; pending[1]=0.
3. mode=2'b01, level[2] clean 0->1 then, 20 cycles later, 1->0 -> rise[2] and edges[2] on the first transition; on the second, fall[2]=1 but edges[2]=0; pending[2] set once.
4. pending[3]=1 already, then clear[3]=1 in the same cycle as a new edges[3] -> pending[3] stays 1. Then clear[3] alone -> pending[3]=0 next cycle; any_pending=0 if no other channel is pending.
5. All four channels 0->1 on the same edge, then reset asserted 2 cycles before the debounce completes -> all outputs 0 immediately; after release with level still 4'hF, all rise bits pulse together 6 edges later.
6. With MULTI_EDGE_DETECTOR_EDGE_CNT_EN and CNT_W=2, mode=2'b11, 5 clean transitions on channel 0 -> edge_count[1:0] reads 1,2,3,3,3 (saturates at 3). Then clear[0] -> 0.

Source files
------------

// File: rtl/multi_edge_detector.sv
// Multi-channel synchronise/debounce edge detector with sticky pending flags.
// Define MULTI_EDGE_DETECTOR_EDGE_CNT_EN to add saturating per-channel edge counters (edge_count).
module multi_edge_detector #(
  parameter int unsigned CH              = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CH-1:0] level,
  input  logic [1:0]    mode,
  input  logic [CH-1:0] clear,
  output logic [CH-1:0] stable,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall,
  output logic [CH-1:0] edges,
  output logic [CH-1:0] pending,
  output logic          any_pending
`ifdef MULTI_EDGE_DETECTOR_EDGE_CNT_EN
  ,
  output logic [CH*CNT_W-1:0] edge_count
`endif
);

  localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  if (CH < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || CNT_W < 1) begin : g_param_check
    $error("multi_edge_detector: illegal parameter value");
  end

  logic [SYNC_STAGES-1:0][CH-1:0] sync_q, sync_d;
  logic [CH-1:0] s;
  logic [CH-1:0] stable_q, stable_d;
  logic [CH-1:0] rise_q, rise_d;
  logic [CH-1:0] fall_q, fall_d;
  logic [CH-1:0] edges_q, edges_d;
  logic [CH-1:0] pending_q, pending_d;
  logic          any_pending_q, any_pending_d;

  assign s = sync_q[SYNC_STAGES-1];

  // Per-channel debounce: accept s only after it has differed from stable for DEBOUNCE_CYCLES edges.
  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [DEB_W-1:0] cnt_q, cnt_d;
    logic             stable_ch_d;

    always_comb begin
      cnt_d       = '0;
      stable_ch_d = stable_q[i];
      if (s[i] != stable_q[i]) begin
        if (cnt_q == DEB_LAST) begin
          stable_ch_d = s[i];
        end else begin
          cnt_d = cnt_q + DEB_W'(1);
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign stable_d[i] = stable_ch_d;

`ifdef MULTI_EDGE_DETECTOR_EDGE_CNT_EN
    logic [CNT_W-1:0] ecnt_q, ecnt_d;

    // A clear coinciding with an edge pulse restarts the count at one.
    always_comb begin
      ecnt_d = ecnt_q;
      if (clear[i]) begin
        ecnt_d = CNT_W'(edges_q[i]);
      end else if (edges_q[i] && (ecnt_q != '1)) begin
        ecnt_d = ecnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        ecnt_q <= '0;
      end else begin
        ecnt_q <= ecnt_d;
      end
    end

    assign edge_count[i*CNT_W +: CNT_W] = ecnt_q;
`endif
  end

  always_comb begin
    sync_d        = {sync_q[SYNC_STAGES-2:0], level};
    rise_d        = stable_d & ~stable_q;
    fall_d        = ~stable_d & stable_q;
    edges_d       = (rise_d & {CH{mode[0]}}) | (fall_d & {CH{mode[1]}});
    // Set wins over clear so an event arriving with a clear is never lost.
    pending_d     = (pending_q & ~clear) | edges_q;
    any_pending_d = |pending_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q        <= '0;
      stable_q      <= '0;
      rise_q        <= '0;
      fall_q        <= '0;
      edges_q       <= '0;
      pending_q     <= '0;
      any_pending_q <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      stable_q      <= stable_d;
      rise_q        <= rise_d;
      fall_q        <= fall_d;
      edges_q       <= edges_d;
      pending_q     <= pending_d;
      any_pending_q <= any_pending_d;
    end
  end

  assign stable      = stable_q;
  assign rise        = rise_q;
  assign fall        = fall_q;
  assign edges       = edges_q;
  assign pending     = pending_q;
  assign any_pending = any_pending_q;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Self-checking bench for multi_edge_detector: windowed behavioural model plus directed literal checks.
module tb_multi_edge_detector;

  localparam int unsigned CH   = 4;
  localparam int unsigned SYNC = 2;
  localparam int unsigned DEB  = 4;
  localparam int unsigned CW   = 2;
  localparam int unsigned HL   = SYNC + DEB;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] level, clear;
  logic [1:0]    mode;
  logic [CH-1:0] stable, rise, fall, edges, pending;
  logic          any_pending;
`ifdef MULTI_EDGE_DETECTOR_EDGE_CNT_EN
  logic [CH*CW-1:0] edge_count;
`endif

  int checks = 0;
  int errors = 0;

  multi_edge_detector #(
    .CH(CH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .level(level), .mode(mode), .clear(clear),
    .stable(stable), .rise(rise), .fall(fall), .edges(edges),
    .pending(pending), .any_pending(any_pending)
`ifdef MULTI_EDGE_DETECTOR_EDGE_CNT_EN
    , .edge_count(edge_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Model: hist holds raw level samples, newest last; s at an edge is the sample SYNC edges earlier.
  logic [CH-1:0] hist [$];
  logic [CH-1:0] m_stable, m_rise, m_fall, m_edges, m_pend, m_new, m_diff, m_bit;
  logic          m_any;
  int unsigned   m_cnt [CH];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      hist.delete();
      for (int k = 0; k < HL; k++) hist.push_back('0);
      m_stable = '0; m_rise = '0; m_fall = '0; m_edges = '0; m_pend = '0; m_any = 1'b0;
      for (int i = 0; i < CH; i++) m_cnt[i] = 0;
    end else begin
      // A channel flips when its last DEB synchronised samples all disagree with stable.
      m_diff = '1;
      for (int j = 0; j < DEB; j++) m_diff = m_diff & (hist[HL-SYNC-j] ^ m_stable);
      m_new = m_stable ^ m_diff;
      for (int i = 0; i < CH; i++) begin
        m_bit = CH'(1) << i;
        if ((clear & m_bit) != '0) m_cnt[i] = ((m_edges & m_bit) != '0) ? 1 : 0;
        else if ((m_edges & m_bit) != '0 && m_cnt[i] < CMAX) m_cnt[i] = m_cnt[i] + 1;
        if ((m_edges & m_bit) != '0) m_pend = m_pend | m_bit;
        else if ((clear & m_bit) != '0) m_pend = m_pend & ~m_bit;
      end
      m_any    = (m_pend != '0);
      m_rise   = m_new & ~m_stable;
      m_fall   = m_stable & ~m_new;
      m_edges  = (mode[0] ? m_rise : '0) | (mode[1] ? m_fall : '0);
      m_stable = m_new;
      hist.push_back(level);
      void'(hist.pop_front());
    end
  end

  always @(negedge clk) begin
    chk("cyc_stable", 32'(stable), 32'(m_stable));
    chk("cyc_rise", 32'(rise), 32'(m_rise));
    chk("cyc_fall", 32'(fall), 32'(m_fall));
    chk("cyc_edges", 32'(edges), 32'(m_edges));
    chk("cyc_pending", 32'(pending), 32'(m_pend));
    chk("cyc_any", 32'(any_pending), 32'(m_any));
`ifdef MULTI_EDGE_DETECTOR_EDGE_CNT_EN
    for (int i = 0; i < CH; i++)
      chk("cyc_edge_count", 32'(edge_count >> (i * CW)) & 32'(CMAX), 32'(m_cnt[i]));
`endif
  end

  logic [CH-1:0] tg;

  initial begin
    reset = 1'b1; level = '0; clear = '0; mode = 2'b11;
    tick(3);
    chk("reset_stable", 32'(stable), 32'h0);
    chk("reset_any", 32'(any_pending), 32'h0);
    reset = 1'b0;
    tick(2);

    // Clean rise on channel 0: visible at edge 5, pending from edge 6.
    level[0] = 1'b1;
    tick(5);
    chk("t1_early", 32'(stable), 32'h0);
    tick(1);
    chk("t1_stable", 32'(stable), 32'h1);
    chk("t1_rise", 32'(rise), 32'h1);
    chk("t1_edges", 32'(edges), 32'h1);
    chk("t1_model_stable", 32'(m_stable), 32'h1);
    chk("t1_pending_late", 32'(pending), 32'h0);
    tick(1);
    chk("t1_rise_off", 32'(rise), 32'h0);
    chk("t1_pending", 32'(pending), 32'h1);
    chk("t1_any", 32'(any_pending), 32'h1);

    // Bounce shorter than the debounce window on channel 1.
    repeat (5) begin
      level[1] = 1'b1; tick(3);
      level[1] = 1'b0; tick(3);
    end
    tick(8);
    chk("t2_stable", 32'(stable & 4'b0010), 32'h0);
    chk("t2_pending", 32'(pending & 4'b0010), 32'h0);

    // Rise-only mode on channel 2.
    mode = 2'b01;
    level[2] = 1'b1;
    tick(6);
    chk("t3_rise", 32'(rise), 32'h4);
    chk("t3_edges", 32'(edges), 32'h4);
    tick(20);
    level[2] = 1'b0;
    tick(6);
    chk("t3_fall", 32'(fall), 32'h4);
    chk("t3_edges_masked", 32'(edges), 32'h0);
    tick(1);
    chk("t3_pending", 32'(pending & 4'b0100), 32'h4);

    // Clear coinciding with a new edge pulse on channel 3.
    mode = 2'b11;
    level[3] = 1'b1;
    tick(7);
    chk("t4_pend_set", 32'(pending & 4'b1000), 32'h8);
    level[3] = 1'b0;
    tick(6);
    chk("t4_edge", 32'(edges), 32'h8);
    clear = 4'b1000;
    tick(1);
    clear = '0;
    chk("t4_set_wins", 32'(pending & 4'b1000), 32'h8);
    clear = 4'b1000;
    tick(1);
    clear = '0;
    chk("t4_cleared", 32'(pending & 4'b1000), 32'h0);
    chk("t4_any_other", 32'(any_pending), 32'h1);
    clear = 4'b0111;
    tick(1);
    clear = '0;
    chk("t4_any_zero", 32'(any_pending), 32'h0);
    chk("t4_pend_zero", 32'(pending), 32'h0);

    // All channels rise together, reset lands mid-debounce, then rise again after release.
    level = '0;
    tick(10);
    level = 4'hF;
    tick(4);
    reset = 1'b1;
    #1;
    chk("t5_rst_stable", 32'(stable), 32'h0);
    chk("t5_rst_pending", 32'(pending), 32'h0);
    chk("t5_rst_any", 32'(any_pending), 32'h0);
    tick(2);
    reset = 1'b0;
    tick(5);
    chk("t5_early", 32'(rise), 32'h0);
    tick(1);
    chk("t5_rise_all", 32'(rise), 32'hF);
    chk("t5_stable_all", 32'(stable), 32'hF);

    // Randomised traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      tg = '0;
      for (int i = 0; i < CH; i++) if ($urandom_range(0, 9) == 0) tg = tg | (CH'(1) << i);
      level = level ^ tg;
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom);
      clear = '0;
      for (int i = 0; i < CH; i++) if ($urandom_range(0, 7) == 0) clear = clear | (CH'(1) << i);
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
      end
      tick(1);
    end
    clear = '0;

`ifdef MULTI_EDGE_DETECTOR_EDGE_CNT_EN
    // Saturating counter on channel 0.
    reset = 1'b1; level = '0; mode = 2'b11;
    tick(2);
    reset = 1'b0;
    tick(2);
    for (int t = 0; t < 5; t++) begin
      level[0] = ~level[0];
      tick(7);
      chk("t6_count", 32'(edge_count) & 32'(CMAX), (t < 3) ? 32'(t + 1) : 32'd3);
      tick(3);
    end
    clear[0] = 1'b1;
    tick(1);
    clear = '0;
    chk("t6_cleared", 32'(edge_count) & 32'(CMAX), 32'h0);
`endif

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
